// File: rtl/pellet_store.sv
// rtl/pellet_store.sv - tile-granular pellet map with eat port, render pixel and pellet count
// Optional frame blink of the rendered dots: `define PELLET_BLINK_EN
module pellet_store #(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int TILE_SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef PELLET_BLINK_EN
  input  logic        frame_tick,
`endif
  input  logic        load,
  output logic        ready,
  input  logic        eat_valid,
  input  logic [9:0]  eat_x,
  input  logic [9:0]  eat_y,
  output logic        eat_ready,
  output logic        eat_done,
  output logic        eat_hit,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic        pellet_pix,
  output logic [10:0] remaining,
  output logic        all_clear
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, FILL, READY} state_t;

  state_t          state, state_next;
  logic [RW-1:0]   fill_row;
  logic [COLS-1:0] map [ROWS];

  // Pellets sit on odd tiles, leaving the outer ring and even lanes empty
  function automatic logic [COLS-1:0] layout_row(input logic [RW-1:0] r);
    logic [COLS-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++)
      v[c] = (c % 2 == 1) && r[0] && (c < COLS - 1) && (int'(r) < ROWS - 1);
    return v;
  endfunction

  function automatic logic [10:0] popcount(input logic [COLS-1:0] v);
    logic [10:0] n;
    n = '0;
    for (int c = 0; c < COLS; c++) n = n + 11'(v[c]);
    return n;
  endfunction

  logic [9:0]    eat_cf, eat_rf, pix_cf, pix_rf;
  logic [CW-1:0] eat_c, pix_c;
  logic [RW-1:0] eat_r, pix_r;
  logic          eat_in, pix_in, eat_bit, pix_bit;
  logic          accept, hit_now, dot, blink_on;
  logic [TILE_SHIFT-1:0] px_low, py_low;

  assign eat_cf  = eat_x >> TILE_SHIFT;
  assign eat_rf  = eat_y >> TILE_SHIFT;
  assign pix_cf  = pix_x >> TILE_SHIFT;
  assign pix_rf  = pix_y >> TILE_SHIFT;
  assign eat_c   = eat_cf[CW-1:0];
  assign eat_r   = eat_rf[RW-1:0];
  assign pix_c   = pix_cf[CW-1:0];
  assign pix_r   = pix_rf[RW-1:0];
  assign eat_in  = (eat_cf < 10'(COLS)) && (eat_rf < 10'(ROWS));
  assign pix_in  = (pix_cf < 10'(COLS)) && (pix_rf < 10'(ROWS));
  assign eat_bit = eat_in ? map[eat_r][eat_c] : 1'b0;
  assign pix_bit = pix_in ? map[pix_r][pix_c] : 1'b0;

  // 4x4 dot centred in the tile
  assign px_low  = pix_x[TILE_SHIFT-1:0];
  assign py_low  = pix_y[TILE_SHIFT-1:0];
  assign dot     = (px_low >= TILE_SHIFT'(6)) && (px_low <= TILE_SHIFT'(9)) &&
                   (py_low >= TILE_SHIFT'(6)) && (py_low <= TILE_SHIFT'(9));

  assign ready     = (state == READY);
  assign eat_ready = ready;
  assign accept    = eat_valid && ready;
  assign hit_now   = accept && eat_bit;
  assign all_clear = ready && (remaining == 11'd0);

`ifdef PELLET_BLINK_EN
  logic [4:0] frame_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= frame_cnt + 5'd1;
  end
  assign blink_on = !frame_cnt[4];
`else
  assign blink_on = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = FILL;
      FILL:    if (load) state_next = FILL;
               else if (fill_row == RW'(ROWS - 1)) state_next = READY;
      READY:   if (load) state_next = FILL;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) map[i] <= '0;
      fill_row   <= '0;
      remaining  <= '0;
      eat_done   <= 1'b0;
      eat_hit    <= 1'b0;
      pellet_pix <= 1'b0;
    end else begin
      eat_done   <= accept;
      eat_hit    <= hit_now;
      pellet_pix <= ready && pix_bit && dot && blink_on;
      if (load) begin
        fill_row  <= '0;
        remaining <= '0;
      end else if (state == FILL) begin
        map[fill_row] <= layout_row(fill_row);
        remaining     <= remaining + popcount(layout_row(fill_row));
        fill_row      <= fill_row + 1'b1;
      end else if (hit_now) begin
        map[eat_r][eat_c] <= 1'b0;
        remaining         <= remaining - 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_pellet_store.sv
// tb/tb_pellet_store.sv - directed bench with eat-result scoreboard for pellet_store
module tb_pellet_store;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        ready;
  logic        eat_valid = 1'b0;
  logic [9:0]  eat_x = '0, eat_y = '0;
  logic        eat_ready, eat_done, eat_hit;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        pellet_pix;
  logic [10:0] remaining;
  logic        all_clear;
`ifdef PELLET_BLINK_EN
  logic        frame_tick = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  bit exp_q[$];
  bit mdl [30][40];
  int mdl_rem;

  always #5 clk = ~clk;

  pellet_store dut (
    .clk(clk), .reset(reset),
`ifdef PELLET_BLINK_EN
    .frame_tick(frame_tick),
`endif
    .load(load), .ready(ready),
    .eat_valid(eat_valid), .eat_x(eat_x), .eat_y(eat_y),
    .eat_ready(eat_ready), .eat_done(eat_done), .eat_hit(eat_hit),
    .pix_x(pix_x), .pix_y(pix_y), .pellet_pix(pellet_pix),
    .remaining(remaining), .all_clear(all_clear)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_fill();
    mdl_rem = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++) begin
        mdl[r][c] = (c % 2 == 1) && (r % 2 == 1) && (c < 39) && (r < 29);
        if (mdl[r][c]) mdl_rem++;
      end
  endfunction

  function automatic bit model_eat(input int x, input int y);
    int c = x >> 4;
    int r = y >> 4;
    if (c >= 40 || r >= 30) return 1'b0;
    if (mdl[r][c]) begin
      mdl[r][c] = 1'b0;
      mdl_rem--;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Scoreboard: every eat_done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (eat_done) begin
      if (exp_q.size() == 0) check("unexpected_eat_done", 1, 0);
      else check("eat_hit", eat_hit, exp_q.pop_front());
    end
  end

  // Entered and left at #1 after a posedge; the request is accepted at the next edge
  task automatic eat_cycle(input int x, input int y);
    eat_valid = 1'b1;
    eat_x = 10'(x);
    eat_y = 10'(y);
    exp_q.push_back(model_eat(x, y));
    @(posedge clk); #1;
  endtask

  task automatic eat_one(input int x, input int y);
    eat_cycle(x, y);
    eat_valid = 1'b0;
  endtask

  task automatic render(input int x, input int y, input bit exp, input string tag);
    pix_x = 10'(x);
    pix_y = 10'(y);
    @(posedge clk);
    @(negedge clk);
    check(tag, pellet_pix, exp);
    #1;
  endtask

  task automatic do_load_and_wait(input string tag);
    bit ok;
    @(posedge clk); #1;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    model_fill();
    ok = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      if (ready !== (k == 31)) ok = 1'b0;
    end
    check({tag, "_ready_latency"}, ok, 1);
    check({tag, "_remaining"}, remaining, 266);
    check({tag, "_model_count"}, remaining, mdl_rem);
    check({tag, "_all_clear"}, all_clear, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit saw_done;
    int budget;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", ready, 0);
    check("reset_remaining", remaining, 0);
    check("reset_pellet_pix", pellet_pix, 0);
    check("reset_eat_done", eat_done, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    eat_valid = 1'b1;
    eat_x = 10'd24;
    eat_y = 10'd24;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (eat_done) saw_done = 1'b1;
    end
    check("idle_eat_ignored", saw_done, 0);
    check("idle_eat_ready", eat_ready, 0);
    @(posedge clk); #1;
    eat_valid = 1'b0;

    do_load_and_wait("load1");

    render(24, 24, 1'b1, "pix_pellet_tile11");
    render(16, 16, 1'b0, "pix_tile11_corner");
    render(24, 40, 1'b0, "pix_tile12_empty");
    render(700, 24, 1'b0, "pix_out_of_range");

    eat_one(24, 24);
    @(negedge clk);
    check("eat11_done", eat_done, 1);
    check("eat11_remaining", remaining, 265);
    @(posedge clk); #1;
    eat_one(24, 24);
    eat_one(32, 16);
    eat_one(700, 10);
    eat_one(8, 480);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("misses_remaining", remaining, 265);
    #1;
    render(24, 24, 1'b0, "pix_after_eat");

    // Same-cycle eat and render of tile (3,1) shows the pre-clear pellet
    pix_x = 10'd56;
    pix_y = 10'd24;
    eat_one(56, 24);
    @(negedge clk);
    check("pix_pre_clear", pellet_pix, 1);
    #1;
    render(56, 24, 1'b0, "pix_post_clear");

    for (int r = 1; r < 30; r += 2)
      for (int c = 1; c < 40; c += 2)
        eat_cycle(c * 16 + 8, r * 16 + 8);
    eat_valid = 1'b0;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    check("cleared_remaining", remaining, 0);
    check("cleared_model", remaining, mdl_rem);
    check("all_clear_set", all_clear, 1);
    #1;
    eat_one(24, 24);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("no_underflow", remaining, 0);
    #1;

    do_load_and_wait("load2");
    render(24, 24, 1'b1, "pix_after_refill");

`ifdef PELLET_BLINK_EN
    pix_x = 10'd24;
    pix_y = 10'd24;
    for (int i = 0; i < 16; i++) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("blink_off", pellet_pix, 0);
    #1;
    for (int i = 0; i < 16; i++) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("blink_on", pellet_pix, 1);
    #1;
`endif

    // Reset right after an accept drops the pending eat_done
    eat_valid = 1'b1;
    eat_x = 10'd40;
    eat_y = 10'd24;
    @(posedge clk); #1;
    eat_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("reset_drops_eat_done", eat_done, 0);
    check("reset_eat_remaining", remaining, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midfill_ready", ready, 0);
    check("midfill_remaining", remaining, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("midfill_stays_idle", ready, 0);
    check("midfill_pix", pellet_pix, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
